cfg_chain_loader: RTL

//  Bitstream loader that feeds the configuration-chain flops. Their mem_out/mem_outb

---
 rtl/cfg_chain_loader_if.sv | 26 ++
 rtl/cfg_chain_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/cfg_chain_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : cfg_chain_loader_if
// Brief   : Bitstream word stream (valid/ready) into the config-chain loader.
// Revision: 1.0
// ============================================================================
interface cfg_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );
endinterface
`default_nettype wire

// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module  : cfg_chain_loader
// Brief   : Serialises bitstream words LSB-first into the configuration chain,
//           counts shifted bits and popcounts the old chain contents.
// Revision: 1.0
// ============================================================================
module cfg_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  wire logic             prog_clk,
   input  wire logic             pReset,
   input  wire logic             start,
   input  wire logic             abort,
   cfg_chain_loader_if.slave     s_if,
   output logic                  ccff_head,
   output logic                  ccff_shift_en,
   input  wire logic             ccff_tail,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      bit_cnt,
   output logic [CNT_W-1:0]      tail_ones
);

   localparam int               WIDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CHAIN_LEN);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [WORD_W-1:0]   shreg_q;
   logic [WIDX_W-1:0]   widx_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [CNT_W-1:0]    tail_ones_q;
   logic                done_q;
   logic [CNT_W-1:0]    bit_cnt_d;
   logic [CNT_W-1:0]    tail_ones_d;

   // Saturating increments; the chain length bound keeps them from wrapping.
   assign bit_cnt_d   = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
   assign tail_ones_d = (tail_ones_q == CNT_SAT) ? tail_ones_q
                                                 : tail_ones_q + CNT_W'(ccff_tail);

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         widx_q      <= '0;
         bit_cnt_q   <= '0;
         tail_ones_q <= '0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q     <= ST_LOAD;
                  bit_cnt_q   <= '0;
                  tail_ones_q <= '0;
                  done_q      <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else if (s_if.s_valid) begin
                  shreg_q <= s_if.s_data;
                  widx_q  <= '0;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else begin
                  shreg_q     <= shreg_q >> 1;
                  widx_q      <= widx_q + WIDX_W'(1);
                  bit_cnt_q   <= bit_cnt_d;
                  tail_ones_q <= tail_ones_d;
                  // Chain end takes priority so a partial last word stops early.
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (widx_q == WIDX_LAST) begin
                     state_q <= ST_LOAD;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_if.s_ready  = (state_q == ST_LOAD);
   assign ccff_shift_en = (state_q == ST_SHIFT);
   assign ccff_head     = shreg_q[0];
   assign busy          = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
   assign done          = done_q;
   assign bit_cnt       = bit_cnt_q;
   assign tail_ones     = tail_ones_q;

endmodule
`default_nettype wire
